// File: rtl/hp_add_scheduler.sv
// ---------------------------------------------------------------------------
// hp_add_scheduler
// Time-shares one combinational half-precision adder/subtractor between
// NUM_REQ requesters. A round-robin arbiter grants one request at a time.
// The granted operands are held on the adder for ADD_LAT cycles. The result
// is then captured and returned with the requester id on a valid/ready
// response channel. No new request is accepted until that response has been
// taken.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot/zero)
//   req_a, req_b, req_op  packed operands (16 bits per requester) and op select
//   add_a, add_b, add_op  registered operands driven to the shared adder
//   add_sum, add_exc      adder result and exception flags
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/sum/exc        owner id, captured sum and captured exceptions
//   busy                  high whenever a request is in flight
//   op_count              completed responses, wraps modulo 2^16
// ---------------------------------------------------------------------------
module hp_add_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_op,
  output logic [15:0]             add_a,
  output logic [15:0]             add_b,
  output logic                    add_op,
  input  logic [15:0]             add_sum,
  input  logic [1:0]              add_exc,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [15:0]             rsp_sum,
  output logic [1:0]              rsp_exc,
  output logic                    busy,
  output logic [15:0]             op_count
);

  localparam int DW = 16;
  // Loaded at grant so that the ISSUE state lasts exactly ADD_LAT cycles.
  localparam logic [3:0] LAT_INIT = 4'(ADD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [15:0]       add_a_q, add_a_d;
  logic [15:0]       add_b_q, add_b_d;
  logic              add_op_q, add_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [15:0]       rsp_sum_q, rsp_sum_d;
  logic [1:0]        rsp_exc_q, rsp_exc_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              win_found_s;
  logic [ID_W-1:0]   win_id_s;
  logic [15:0]       sel_a_s;
  logic [15:0]       sel_b_s;
  logic              sel_op_s;
  logic [NUM_REQ-1:0] req_ready_s;
  int                best_dist_s;
  int                dist_s;

  // Round-robin winner: the valid requester with the smallest upward
  // distance from rr_ptr (modulo NUM_REQ) wins.
  always_comb begin
    best_dist_s = NUM_REQ;
    dist_s      = 0;
    win_id_s    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        dist_s = (i + NUM_REQ - int'(rr_ptr_q)) % NUM_REQ;
        if (dist_s < best_dist_s) begin
          best_dist_s = dist_s;
          win_id_s    = ID_W'(i);
        end else begin
          best_dist_s = best_dist_s;
        end
      end else begin
        dist_s = dist_s;
      end
    end
    win_found_s = (best_dist_s < NUM_REQ);
  end

  // Operand mux for the winner and the one-hot accept (only while IDLE).
  always_comb begin
    sel_a_s     = '0;
    sel_b_s     = '0;
    sel_op_s    = 1'b0;
    req_ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_found_s && (win_id_s == ID_W'(i))) begin
        sel_a_s        = req_a[i*DW +: DW];
        sel_b_s        = req_b[i*DW +: DW];
        sel_op_s       = req_op[i];
        req_ready_s[i] = (state_q == ST_IDLE);
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  // Next-state and datapath update for the IDLE -> ISSUE -> RESP cycle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lat_cnt_d   = lat_cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_op_d    = add_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_exc_d   = rsp_exc_q;
    op_count_d  = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          add_a_d   = sel_a_s;
          add_b_d   = sel_b_s;
          add_op_d  = sel_op_s;
          rsp_id_d  = win_id_s;
          lat_cnt_d = LAT_INIT;
          state_d   = ST_ISSUE;
          // Wrap explicitly: NUM_REQ need not be a power of two.
          if (win_id_s == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = win_id_s + ID_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (lat_cnt_q != 4'd0) begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end else begin
          rsp_sum_d   = add_sum;
          rsp_exc_d   = add_exc;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      lat_cnt_q   <= 4'd0;
      add_a_q     <= 16'd0;
      add_b_q     <= 16'd0;
      add_op_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= 16'd0;
      rsp_exc_q   <= 2'd0;
      op_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_cnt_q   <= lat_cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_op_q    <= add_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_exc_q   <= rsp_exc_d;
      op_count_q  <= op_count_d;
    end
  end

  assign req_ready = req_ready_s;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_op    = add_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_exc   = rsp_exc_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_hp_add_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for hp_add_scheduler: directed vector table, round-robin order,
// backpressure, mid-operation reset, latency for ADD_LAT=1/2/5, op_count
// wrap, and a randomized run against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_hp_add_scheduler;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_op;
  logic [16*N-1:0] req_a, req_b;
  logic            rsp_ready;

  logic [N-1:0]  req_ready;
  logic [15:0]   add_a, add_b, add_sum, rsp_sum, op_count;
  logic          add_op, rsp_valid, busy;
  logic [1:0]    add_exc, rsp_exc;
  logic [IW-1:0] rsp_id;

  logic [N-1:0]  l1_req_ready, l5_req_ready;
  logic [15:0]   l1_add_a, l1_add_b, l1_add_sum, l1_rsp_sum, l1_op_count;
  logic [15:0]   l5_add_a, l5_add_b, l5_add_sum, l5_rsp_sum, l5_op_count;
  logic          l1_add_op, l1_rsp_valid, l1_busy, l5_add_op, l5_rsp_valid, l5_busy;
  logic [1:0]    l1_add_exc, l1_rsp_exc, l5_add_exc, l5_rsp_exc;
  logic [IW-1:0] l1_rsp_id, l5_rsp_id;

  // Stand-in adder: any deterministic function of the operands will do.
  function automatic logic [17:0] fake_add(logic [15:0] a, logic [15:0] b, logic op);
    logic [15:0] s;
    logic [1:0]  e;
    if (a == 16'h3C00 && b == 16'h3C00 && !op) s = 16'h4000;
    else if (op) s = a - b;
    else s = a ^ {b[7:0], b[15:8]};
    e = {a[0] ^ b[1], op};
    return {e, s};
  endfunction

  assign {add_exc, add_sum}       = fake_add(add_a, add_b, add_op);
  assign {l1_add_exc, l1_add_sum} = fake_add(l1_add_a, l1_add_b, l1_add_op);
  assign {l5_add_exc, l5_add_sum} = fake_add(l5_add_a, l5_add_b, l5_add_op);

  hp_add_scheduler #(.NUM_REQ(N), .ID_W(IW), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .add_a(add_a), .add_b(add_b),
    .add_op(add_op), .add_sum(add_sum), .add_exc(add_exc), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_exc(rsp_exc),
    .busy(busy), .op_count(op_count));

  hp_add_scheduler #(.NUM_REQ(N), .ID_W(IW), .ADD_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(l1_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .add_a(l1_add_a), .add_b(l1_add_b),
    .add_op(l1_add_op), .add_sum(l1_add_sum), .add_exc(l1_add_exc), .rsp_valid(l1_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(l1_rsp_id), .rsp_sum(l1_rsp_sum), .rsp_exc(l1_rsp_exc),
    .busy(l1_busy), .op_count(l1_op_count));

  hp_add_scheduler #(.NUM_REQ(N), .ID_W(IW), .ADD_LAT(5)) dut_l5 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(l5_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .add_a(l5_add_a), .add_b(l5_add_b),
    .add_op(l5_add_op), .add_sum(l5_add_sum), .add_exc(l5_add_exc), .rsp_valid(l5_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(l5_rsp_id), .rsp_sum(l5_rsp_sum), .rsp_exc(l5_rsp_exc),
    .busy(l5_busy), .op_count(l5_op_count));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] sum;
    logic [1:0]  exc;
  } vec_t;
  vec_t vecs[4];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(int idx, logic [15:0] a, logic [15:0] b, logic op);
    req_a[idx*16 +: 16] = a;
    req_b[idx*16 +: 16] = b;
    req_op[idx]         = op;
  endtask

  // One isolated operation on the main instance, fully checked.
  task automatic run_one(vec_t v, int exp_cnt);
    int cyc;
    @(negedge clk);
    req_valid = '0; req_valid[v.idx] = 1'b1; rsp_ready = 1'b1;
    drive(v.idx, v.a, v.b, v.op);
    #1 chk("grant", 32'(req_ready), 32'd1 << v.idx);
    @(negedge clk);
    req_valid = '0; cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk); cyc++;
    end
    chk("latency", 32'(cyc), 32'(LAT + 1));
    chk("rsp_id", 32'(rsp_id), 32'(v.idx));
    chk("rsp_sum", 32'(rsp_sum), 32'(v.sum));
    chk("rsp_exc", 32'(rsp_exc), 32'(v.exc));
    @(negedge clk);
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  // Reference model state (transaction level).
  int          m_ptr, m_timer;
  bit          m_inflight, m_resp;
  logic [15:0] m_a, m_b, m_sum, m_cnt;
  logic        m_op;
  logic [1:0]  m_exc;
  int          m_id;

  initial begin
    int g, r, t1, t5, exp_w, w;
    logic [N-1:0] exp_rdy;
    vecs[0] = '{2, 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 2'b00};
    vecs[1] = '{0, 16'h1234, 16'h0010, 1'b1, 16'h1224, 2'b01};
    vecs[2] = '{3, 16'h0001, 16'h0100, 1'b0, 16'h0000, 2'b10};
    vecs[3] = '{1, 16'hC000, 16'h4003, 1'b1, 16'h7FFD, 2'b11};

    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors
    for (int k = 0; k < 4; k++) run_one(vecs[k], k + 1);

    // Round-robin order with all requesters continuously valid
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) drive(i, 16'(i * 3 + 1), 16'(i + 7), i[0]);
    req_valid = '1; rsp_ready = 1'b1; g = 0; r = 0;
    for (int c = 0; c < 200 && (g < 8 || r < 8); c++) begin
      #1;
      if (req_ready != '0) begin chk("rr_grant", 32'(req_ready), 32'd1 << (g % N)); g++; end
      if (rsp_valid) begin chk("rr_rsp_id", 32'(rsp_id), 32'(r % N)); r++; end
      @(negedge clk);
      if (g >= 8) req_valid = '0;
    end
    chk("rr_grants", 32'(g), 32'd8);
    chk("rr_count", 32'(op_count), 32'd8);

    // Response backpressure
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; rsp_ready = 1'b0; drive(1, vecs[1].a, vecs[1].b, vecs[1].op);
    #1 chk("bp_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b1001;
    for (int c = 0; c < 40 && !rsp_valid; c++) begin
      #1 chk("bp_ready_issue", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_sum", 32'(rsp_sum), 32'h1224);
      chk("bp_exc", 32'(rsp_exc), 32'h1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_ready_accept", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'h8);
    chk("bp_count", 32'(op_count), 32'd1);
    @(negedge clk); req_valid = '0;
    repeat (6) @(negedge clk);

    // Reset in the second ISSUE cycle
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; rsp_ready = 1'b1; drive(1, 16'h1234, 16'h5678, 1'b1);
    @(negedge clk); req_valid = '0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_add_a", 32'(add_a), 32'd0);
    chk("mid_add_b", 32'(add_b), 32'd0);
    chk("mid_add_op", 32'(add_op), 32'd0);
    chk("mid_rsp", {rsp_valid, 12'd0, rsp_id, rsp_exc, rsp_sum}, 32'd0);
    chk("mid_count", 32'(op_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    r = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) r++; end
    chk("mid_no_rsp", 32'(r), 32'd0);
    req_valid = 4'b1010;
    #1 chk("mid_ptr_cleared", 32'(req_ready), 32'h2);
    @(negedge clk); req_valid = '0;
    repeat (6) @(negedge clk);

    // ADD_LAT=1 vs ADD_LAT=5 on identical operands
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001; rsp_ready = 1'b1; drive(0, 16'h5555, 16'h0F0F, 1'b0);
    #1;
    chk("l1_grant", 32'(l1_req_ready), 32'h1);
    chk("l5_grant", 32'(l5_req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0; drive(0, 16'hFFFF, 16'hFFFF, 1'b1);
    t1 = 0; t5 = 0;
    for (int c = 1; c <= 9; c++) begin
      if (l1_rsp_valid && t1 == 0) t1 = c;
      if (l5_rsp_valid && t5 == 0) t5 = c;
      if (c <= 6) chk("l5_hold", {l5_add_a, l5_add_b}, 32'h55550F0F);
      @(negedge clk);
    end
    chk("l1_latency", 32'(t1), 32'd2);
    chk("l5_latency", 32'(t5), 32'd6);
    chk("l5_sum", 32'(l5_rsp_sum), 32'(16'h5555 ^ 16'h0F0F));
    repeat (4) @(negedge clk);

    // op_count wrap
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk);
    run_one(vecs[0], 0);

    // Randomized run against the reference model
    do_reset();
    m_ptr = 0; m_inflight = 0; m_resp = 0; m_timer = 0;
    m_a = '0; m_b = '0; m_op = 1'b0; m_sum = '0; m_exc = '0; m_cnt = '0; m_id = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) drive(i, 16'($urandom), 16'($urandom), 1'($urandom));
      rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_rdy = '0; w = -1;
      if (!m_inflight && !m_resp) begin
        for (int k = 0; k < N && w < 0; k++) begin
          exp_w = (m_ptr + k) % N;
          if (req_valid[exp_w]) w = exp_w;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_busy", 32'(busy), 32'(m_inflight || m_resp));
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rnd_rsp_data", {14'd0, rsp_exc, rsp_sum}, {14'd0, m_exc, m_sum});
      chk("rnd_add_ops", {add_op, add_a, add_b[14:0]}, {m_op, m_a, m_b[14:0]});
      chk("rnd_op_count", 32'(op_count), 32'(m_cnt));
      if (w >= 0) begin
        m_inflight = 1; m_timer = LAT; m_id = w; m_ptr = (w + 1) % N;
        m_a = req_a[w*16 +: 16]; m_b = req_b[w*16 +: 16]; m_op = req_op[w];
      end else if (m_inflight) begin
        m_timer--;
        if (m_timer == 0) begin
          m_inflight = 0; m_resp = 1;
          {m_exc, m_sum} = fake_add(m_a, m_b, m_op);
        end
      end else if (m_resp && rsp_ready) begin
        m_resp = 0; m_cnt = m_cnt + 16'd1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
